timer_irq: RTL

Memory-mapped interval timer that raises the `IRQ` line consumed by the pipeline's control decoder. It sits on the data-memory bus beside the data RAM, decodes its own address window from the MEM-stage `Address`/`MemRead`/`MemWrite` signals, counts on every clock, and asserts `IRQ` on counter overflow when interrupts are enabled. It also provides a free-running cycle counter for software timing.

---
 rtl/timer_irq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/timer_irq.sv
// Memory-mapped interval timer with reload, sticky overflow status, interrupt line and free-running cycle counter.
// Latency: reads are combinational (0 cycles); writes and counting take effect at the next rising edge.
// Backpressure: none; every bus access completes in its own cycle, so the bus is never stalled.
module timer_irq #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        IRQ
);

    // Word offsets inside the 32-byte window.
    localparam logic [2:0] OFF_TH      = 3'd0;
    localparam logic [2:0] OFF_TL      = 3'd1;
    localparam logic [2:0] OFF_TCON    = 3'd2;
    localparam logic [2:0] OFF_SYSTICK = 3'd5;

    logic [31:0] th;
    logic [31:0] tl;
    logic [31:0] systick;
    logic        en;
    logic        ie;
    logic        st;

    logic [2:0]  off;
    logic        wr_hit;
    logic        wr_th;
    logic        wr_tl;
    logic        wr_tcon;
    logic        tl_max;
    logic        ovf;
    logic        st_set;
    logic        unused_addr_bits;

    // Byte-lane bits are ignored; the window is decoded on the upper 27 bits.
    assign unused_addr_bits = ^Address[1:0];
    assign off              = Address[4:2];
    assign Hit              = (Address[31:5] == BASE_ADDR[31:5]);

    assign wr_hit  = MemWrite & Hit;
    assign wr_th   = wr_hit & (off == OFF_TH);
    assign wr_tl   = wr_hit & (off == OFF_TL);
    assign wr_tcon = wr_hit & (off == OFF_TCON);

    // A software write to TL overrides the counter that cycle, so it also
    // cancels the overflow (no reload, no status set) the old value implied.
    assign tl_max = (tl == 32'hFFFF_FFFF);
    assign ovf    = en & tl_max & ~wr_tl;
    assign st_set = ovf & ie;

    // Level interrupt purely from registers, so it never glitches on bus activity.
    assign IRQ = ie & st;

    // Reload register: software write only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th <= 32'd0;
        end else if (wr_th) begin
            th <= WriteData;
        end
    end

    // Counter: software write wins, otherwise count and reload from the pre-edge TH on overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tl <= 32'd0;
        end else if (wr_tl) begin
            tl <= WriteData;
        end else if (en) begin
            tl <= tl_max ? th : tl + 32'd1;
        end
    end

    // Control/status: hardware overflow set beats a software clear so no interrupt is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en <= 1'b0;
            ie <= 1'b0;
            st <= 1'b0;
        end else begin
            if (wr_tcon) begin
                en <= WriteData[0];
                ie <= WriteData[1];
            end
            if (st_set) begin
                st <= 1'b1;
            end else if (wr_tcon) begin
                st <= WriteData[2];
            end
        end
    end

    // Free-running cycle counter, read-only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick <= 32'd0;
        end else begin
            systick <= systick + 32'd1;
        end
    end

    // Combinational read mux; zero whenever the access is not a read into the window.
    always_comb begin
        ReadData = 32'd0;
        if (MemRead && Hit) begin
            case (off)
                OFF_TH:      ReadData = th;
                OFF_TL:      ReadData = tl;
                OFF_TCON:    ReadData = {29'd0, st, ie, en};
                OFF_SYSTICK: ReadData = systick;
                default:     ReadData = 32'd0;
            endcase
        end
    end

endmodule
